sa2_skew_feeder: RTL and testbench
==================================

Name: sa2_skew_feeder

Overview:
- Upstream feeder for the 2x2 weight/activation systolic array.
- Accepts one K-deep tile per start: per beat, one activation column {a_row0[k], a_row1[k]} and one weight row {b_col0[k], b_col1[k]}.
- Emits the diagonally skewed, zero-padded operand streams and the accumulate control the array consumes.
- Signals when the array's 4 accumulators hold the final tile result.

Parameters:
WIDTH, 8, operand width per lane (matches array WIDTH)
K_MAX, 256, maximum beats per tile
DRAIN_CYC, 3, cycles after last accepted beat until the last PE has consumed its operands

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  pulse; arms a new tile (ignored unless IDLE)
in_valid  input  1  beat valid
in_ready  output  1  beat accept; high only in STREAM
in_act  input  2*WIDTH  {a_row0[k], a_row1[k]}
in_wt  input  2*WIDTH  {b_col0[k], b_col1[k]}
in_last  input  1  marks final beat of tile
sa_activation  output  2*WIDTH  to array activation port {act_0, act_1}
sa_weight  output  2*WIDTH  to array weight port {weight_0, weight_1}
sa_control  output  1  1 = PEs accumulate, 0 = PEs clear
busy  output  1  high in any state but IDLE
result_valid  output  1  one-cycle pulse: array c_out is final
beat_count  output  $clog2(K_MAX+1)  beats accepted this tile
overflow  output  1  sticky; K_MAX beats accepted without in_last

Behaviour:
- Reset: state IDLE. All outputs 0 (sa_activation, sa_weight, sa_control, busy, result_valid, beat_count, overflow, in_ready). Skew registers are cleared. Reset mid-tile abandons the tile with no result_valid.
- FSM: IDLE -start-> CLEAR (1 cycle) -> STREAM -accept with in_last-> DRAIN (DRAIN_CYC cycles) -> IDLE.
- IDLE: sa_control=0, operands 0.
- CLEAR: sa_control=0, which zeroes the PE accumulators. beat_count and overflow are cleared.
- STREAM: in_ready=1, sa_control=1. in_valid low inserts a bubble: zero operands into the lane-0 registers.
- Skew: an accepted beat at edge t drives sa_activation[2W-1:W]=a_row0[k] and sa_weight[2W-1:W]=b_col0[k] in cycle t+1.
  - a_row1[k] and b_col1[k] appear on the low halves in cycle t+2, through one extra register stage per lane-1 path.
  - A lane not fed in a cycle outputs 0.
- DRAIN: in_ready=0, sa_control=1. Lane-0 inputs are 0; the lane-1 skew register flushes its last value.
- Exit: on the DRAIN_CYC-th drain cycle, state returns to IDLE. The next cycle has result_valid=1, sa_control=0, busy=0.
  - Last beat at edge tL gives result_valid in cycle tL+DRAIN_CYC+1, i.e. tL+4 by default.
- beat_count: increments per accepted beat and saturates at K_MAX.
- Beat K_MAX accepted without in_last: overflow=1 and the tile is forced into DRAIN as if in_last were set.
- start while busy: ignored, with no effect on the current tile.
- start in the same cycle as result_valid: accepted, entering CLEAR the next cycle.
- in_last on a bubble (in_valid=0): ignored.
- Arithmetic: data passes through unmodified; there are no width changes.

Decomposition:
- Shared package holds FSM state encoding (IDLE, CLEAR, STREAM, DRAIN) and the default array geometry constants (rows=2, cols=2, PE hop latency=1).
- One natural sub-module, skew_delay_line: a per-lane N-stage register chain with synchronous clear, instantiated at depth 1 for lane 1 of both activation and weight. Lane 0 is depth 0.

Test Plan:
- Reset mid-STREAM (rst high 1 cycle after 2 beats) -> next cycle all outputs 0, state IDLE, no result_valid; a following start works normally.
- K=1, a=(3,5), b=(2,7), start then a single beat with in_last:
  - cycle t+1: sa_activation={3,0}, sa_weight={2,0};
  - cycle t+2: {0,5} and {0,7};
  - result_valid at t+4; the downstream array c_out reads {6,21,10,35}.
- K=3 back-to-back beats, then a second start in the result_valid cycle -> CLEAR one cycle later, beat_count restarts at 0, and the first tile's c_out matches a software 2x2 dot-product model.
- Bubbles: K=4 with in_valid low between beats 2 and 3 for 2 cycles -> zero operands inserted, result unchanged vs. the no-bubble run, result_valid delayed by exactly 2 cycles.
- Overflow: K_MAX=4, 4 beats with in_last never set -> overflow=1 after beat 4, DRAIN entered, result_valid 4 cycles after beat 4, beat_count=4.
- start while busy and in_last on a bubble -> both ignored; the tile completes with the original beat count.

Source files
------------

// File: rtl/sa2_skew_feeder_pkg.sv
// sa2_skew_feeder_pkg: FSM encoding and the 2x2 array geometry the feeder skews for.
package sa2_skew_feeder_pkg;
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_STREAM, S_DRAIN} state_t;
  localparam int SA_ROWS = 2;
  localparam int SA_COLS = 2;
  localparam int PE_HOP = 1;
  localparam int LANE1_SKEW = PE_HOP * (SA_ROWS - 1);
endpackage

// File: rtl/sa2_skew_feeder_skew_delay_line.sv
// skew_delay_line: DEPTH-stage register chain with synchronous clear; DEPTH=0 is a wire.
module skew_delay_line
  import sa2_skew_feeder_pkg::*;
#(
  parameter int W = 8,
  parameter int DEPTH = LANE1_SKEW
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  if (DEPTH == 0) begin : g_wire
    assign q = d;
  end else begin : g_reg
    logic [DEPTH*W-1:0] r_sr;
    always_ff @(posedge clk)
      r_sr <= clr ? '0 : (DEPTH*W)'({r_sr, d});
    assign q = r_sr[DEPTH*W-1 -: W];
  end
endmodule

// File: rtl/sa2_skew_feeder.sv
// sa2_skew_feeder: skews K-beat operand tiles into a 2x2 systolic array and flags the final result.
module sa2_skew_feeder
  import sa2_skew_feeder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int K_MAX = 256,
  parameter int DRAIN_CYC = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2*WIDTH-1:0]         in_act,
  input  logic [2*WIDTH-1:0]         in_wt,
  input  logic                       in_last,
  output logic [2*WIDTH-1:0]         sa_activation,
  output logic [2*WIDTH-1:0]         sa_weight,
  output logic                       sa_control,
  output logic                       busy,
  output logic                       result_valid,
  output logic [$clog2(K_MAX+1)-1:0] beat_count,
  output logic                       overflow
);
  localparam int CW = $clog2(K_MAX + 1);
  localparam int DW = $clog2(DRAIN_CYC + 1);
  state_t r_state;
  logic [DW-1:0] r_drain;
  logic [CW-1:0] r_cnt;
  logic r_ovf, r_rv;
  logic [WIDTH-1:0] r_act0, r_act1, r_wt0, r_wt1, w_act1, w_wt1;
  logic w_acc, w_end, w_drain_done;
  assign w_acc = (r_state == S_STREAM) && in_valid;
  // Hitting K_MAX closes the tile exactly as an in_last would.
  assign w_end = w_acc && (in_last || r_cnt == CW'(K_MAX - 1));
  assign w_drain_done = (r_state == S_DRAIN) && (r_drain == DW'(DRAIN_CYC - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_drain <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_rv    <= 1'b0;
      r_act0  <= '0;
      r_act1  <= '0;
      r_wt0   <= '0;
      r_wt1   <= '0;
    end else begin
      r_rv   <= w_drain_done;
      r_act0 <= w_acc ? in_act[2*WIDTH-1:WIDTH] : '0;
      r_act1 <= w_acc ? in_act[WIDTH-1:0] : '0;
      r_wt0  <= w_acc ? in_wt[2*WIDTH-1:WIDTH] : '0;
      r_wt1  <= w_acc ? in_wt[WIDTH-1:0] : '0;
      r_drain <= (r_state == S_DRAIN) ? r_drain + 1'b1 : '0;
      if (r_state == S_IDLE && start) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else begin
        r_cnt <= (w_acc && r_cnt != CW'(K_MAX)) ? r_cnt + 1'b1 : r_cnt;
        r_ovf <= r_ovf | (w_end && !in_last);
      end
      case (r_state)
        S_IDLE:   r_state <= start ? S_CLEAR : S_IDLE;
        S_CLEAR:  r_state <= S_STREAM;
        S_STREAM: r_state <= w_end ? S_DRAIN : S_STREAM;
        default:  r_state <= w_drain_done ? S_IDLE : S_DRAIN;
      endcase
    end
  end
  skew_delay_line #(.W(WIDTH), .DEPTH(LANE1_SKEW)) u_act1 (
    .clk(clk), .clr(rst), .d(r_act1), .q(w_act1)
  );
  skew_delay_line #(.W(WIDTH), .DEPTH(LANE1_SKEW)) u_wt1 (
    .clk(clk), .clr(rst), .d(r_wt1), .q(w_wt1)
  );
  assign in_ready      = r_state == S_STREAM;
  assign sa_control    = (r_state == S_STREAM) || (r_state == S_DRAIN);
  assign busy          = r_state != S_IDLE;
  assign result_valid  = r_rv;
  assign beat_count    = r_cnt;
  assign overflow      = r_ovf;
  assign sa_activation = {r_act0, w_act1};
  assign sa_weight     = {r_wt0, w_wt1};
endmodule

// File: tb/tb_sa2_skew_feeder.sv
// tb_sa2_skew_feeder: directed tiles checked against a spec-level model and a 2x2 array model.
module tb_sa2_skew_feeder;
  localparam int K_MAX = 4;
  localparam int DRAIN_CYC = 3;
  logic clk = 1'b0;
  logic rst, start, in_valid, in_last;
  logic [15:0] in_act, in_wt;
  logic in_ready, sa_control, busy, result_valid, overflow;
  logic [15:0] sa_activation, sa_weight;
  logic [2:0] beat_count;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  always #5 clk = ~clk;
  sa2_skew_feeder #(.WIDTH(8), .K_MAX(K_MAX), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_act(in_act), .in_wt(in_wt), .in_last(in_last),
    .sa_activation(sa_activation), .sa_weight(sa_weight), .sa_control(sa_control),
    .busy(busy), .result_valid(result_valid), .beat_count(beat_count), .overflow(overflow)
  );
  function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", n, a, e, $time);
    end
  endfunction
  // Spec-level model: phase, accepted-beat history and software dot product.
  int m_phase = 0, m_left = 0, m_cnt = 0;
  bit m_ovf = 0, m_rv = 0;
  logic [15:0] p1a = 0, p1w = 0, p2a = 0, p2w = 0;
  longint sw [4];
  always @(posedge clk) begin
    bit acc;
    cyc++;
    acc = (m_phase == 2) && in_valid;
    if (rst) begin
      m_phase = 0; m_left = 0; m_cnt = 0; m_ovf = 0; m_rv = 0;
      p1a = 0; p1w = 0; p2a = 0; p2w = 0;
    end else begin
      p2a = p1a; p2w = p1w;
      p1a = acc ? in_act : 16'h0;
      p1w = acc ? in_wt : 16'h0;
      m_rv = 0;
      if (m_phase == 0 && start) begin
        m_phase = 1; m_cnt = 0; m_ovf = 0;
        for (int i = 0; i < 4; i++) sw[i] = 0;
      end else if (m_phase == 1) m_phase = 2;
      else if (m_phase == 2 && acc) begin
        if (m_cnt < K_MAX) m_cnt++;
        sw[0] += longint'(in_act[15:8]) * longint'(in_wt[15:8]);
        sw[1] += longint'(in_act[15:8]) * longint'(in_wt[7:0]);
        sw[2] += longint'(in_act[7:0]) * longint'(in_wt[15:8]);
        sw[3] += longint'(in_act[7:0]) * longint'(in_wt[7:0]);
        if (in_last || m_cnt == K_MAX) begin
          m_ovf = !in_last; m_phase = 3; m_left = DRAIN_CYC;
        end
      end else if (m_phase == 3) begin
        m_left--;
        if (m_left == 0) begin m_phase = 0; m_rv = 1; end
      end
    end
  end
  // Downstream 2x2 output-stationary array, one hop per PE.
  longint c [4];
  logic [7:0] ah_d = 0, al_d = 0, wh_d = 0, wl_d = 0;
  always @(posedge clk) begin
    c[0] = sa_control ? c[0] + sa_activation[15:8] * sa_weight[15:8] : 0;
    c[1] = sa_control ? c[1] + ah_d * sa_weight[7:0] : 0;
    c[2] = sa_control ? c[2] + sa_activation[7:0] * wh_d : 0;
    c[3] = sa_control ? c[3] + al_d * wl_d : 0;
    ah_d = sa_activation[15:8]; al_d = sa_activation[7:0];
    wh_d = sa_weight[15:8]; wl_d = sa_weight[7:0];
  end
  always @(negedge clk) if (chk_en) begin
    chk("in_ready", in_ready, m_phase == 2);
    chk("sa_control", sa_control, m_phase >= 2);
    chk("busy", busy, m_phase != 0);
    chk("result_valid", result_valid, m_rv);
    chk("beat_count", beat_count, m_cnt);
    chk("overflow", overflow, m_ovf);
    chk("sa_activation", sa_activation, {p1a[15:8], p2a[7:0]});
    chk("sa_weight", sa_weight, {p1w[15:8], p2w[7:0]});
    if (m_rv) for (int i = 0; i < 4; i++) chk("c_out_vs_sw", c[i], sw[i]);
  end
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask
  task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic last);
    in_valid = 1'b1; in_act = a; in_wt = b; in_last = last;
    @(negedge clk);
    in_valid = 1'b0; in_act = 16'h0; in_wt = 16'h0; in_last = 1'b0;
  endtask
  task automatic wait_rv();
    int n = 0;
    while (!result_valid && n < 40) begin @(negedge clk); n++; end
    chk("rv_seen", result_valid, 1'b1);
  endtask
  int t0, lat0;
  longint c_ref [4];
  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_act = 0; in_wt = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_act", sa_activation, 16'h0);
    chk("rst_ready", in_ready, 1'b0);
    // reset in the middle of a tile
    do_start();
    beat(16'h0102, 16'h0304, 1'b0);
    beat(16'h0506, 16'h0708, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_act", sa_activation, 16'h0);
    chk("midrst_wt", sa_weight, 16'h0);
    chk("midrst_cnt", beat_count, 3'd0);
    chk("midrst_ctl", sa_control, 1'b0);
    repeat (3) @(negedge clk);
    // K=1 skew and result pinned by hand
    do_start();
    beat(16'h0305, 16'h0207, 1'b1);
    chk("k1_act_t1", sa_activation, 16'h0300);
    chk("k1_wt_t1", sa_weight, 16'h0200);
    @(negedge clk);
    chk("k1_act_t2", sa_activation, 16'h0005);
    chk("k1_wt_t2", sa_weight, 16'h0007);
    @(negedge clk);
    chk("k1_rv_t3", result_valid, 1'b0);
    @(negedge clk);
    chk("k1_rv_t4", result_valid, 1'b1);
    chk("k1_c00", c[0], 6);
    chk("k1_c01", c[1], 21);
    chk("k1_c10", c[2], 10);
    chk("k1_c11", c[3], 35);
    @(negedge clk);
    // K=3 back-to-back, restart in the result_valid cycle
    do_start();
    beat(16'h0102, 16'h0101, 1'b0);
    beat(16'h0304, 16'h0200, 1'b0);
    beat(16'h0506, 16'h0003, 1'b1);
    wait_rv();
    chk("k3_c00", c[0], 7);
    chk("k3_c01", c[1], 16);
    chk("k3_c10", c[2], 10);
    chk("k3_c11", c[3], 20);
    chk("k3_cnt", beat_count, 3'd3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_busy", busy, 1'b1);
    chk("restart_ctl", sa_control, 1'b0);
    chk("restart_cnt", beat_count, 3'd0);
    @(negedge clk);
    // K=4 reference run without bubbles
    t0 = cyc;
    beat(16'h0102, 16'h0100, 1'b0);
    beat(16'h0304, 16'h0001, 1'b0);
    beat(16'h0506, 16'h0202, 1'b0);
    beat(16'h0708, 16'h0103, 1'b1);
    wait_rv();
    lat0 = cyc - t0;
    chk("nb_latency", lat0, 7);
    for (int i = 0; i < 4; i++) c_ref[i] = c[i];
    // same tile with a 2-cycle bubble, start and in_last on bubbles
    do_start();
    t0 = cyc;
    beat(16'h0102, 16'h0100, 1'b0);
    beat(16'h0304, 16'h0001, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_last = 1'b1;
    @(negedge clk);
    in_last = 1'b0;
    chk("bub_ready", in_ready, 1'b1);
    beat(16'h0506, 16'h0202, 1'b0);
    beat(16'h0708, 16'h0103, 1'b1);
    wait_rv();
    chk("bub_latency", cyc - t0, lat0 + 2);
    for (int i = 0; i < 4; i++) chk("bub_c_same", c[i], c_ref[i]);
    chk("bub_cnt", beat_count, 3'd4);
    chk("bub_ovf", overflow, 1'b0);
    @(negedge clk);
    // overflow: K_MAX beats with no in_last
    do_start();
    beat(16'h0101, 16'h0101, 1'b0);
    beat(16'h0202, 16'h0202, 1'b0);
    beat(16'h0303, 16'h0303, 1'b0);
    beat(16'h0404, 16'h0404, 1'b0);
    t0 = cyc;
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_cnt", beat_count, 3'd4);
    chk("ovf_ready", in_ready, 1'b0);
    wait_rv();
    chk("ovf_rv_delay", cyc - t0, 3);
    chk("ovf_cnt_rv", beat_count, 3'd4);
    chk("ovf_c00", c[0], 30);
    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
